// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
//
// Sequencing stage that sits directly in front of the 8-bit combinational
// ALU. It takes one command at a time over a valid/ready handshake. Each
// command gets its operands from a 4 x 8-bit register file, or from an
// immediate value. The block presents the operands to the ALU, writes the
// ALU result back into the destination register one cycle later, and
// returns the result over a valid/ready response port.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   cmd_valid    in   command offered
//   cmd_ready    out  block can accept a command (registered)
//   cmd_op       in   [2:0] 0 add, 1 sub, 2 and, 3 or, 4 not-a, 5..7 illegal
//   cmd_src_a    in   [1:0] register index for operand A
//   cmd_src_b    in   [1:0] register index for operand B
//   cmd_imm_sel  in   1: operand B is cmd_imm, 0: operand B is reg[cmd_src_b]
//   cmd_imm      in   [7:0] immediate operand
//   cmd_dst      in   [1:0] destination register index
//   alu_opcode   out  [2:0] to ALU opcode
//   alu_a        out  [7:0] to ALU operand a
//   alu_b        out  [7:0] to ALU operand b
//   alu_result   in   [7:0] from ALU (combinational)
//   rsp_valid    out  result available
//   rsp_ready    in   consumer accepts result
//   rsp_data     out  [7:0] result value (0 for an illegal opcode)
//   rsp_zero     out  rsp_data == 0 (legal ops only)
//   rsp_err      out  command carried an illegal opcode
// ---------------------------------------------------------------------------
module alu_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [1:0] cmd_src_a,
  input  logic [1:0] cmd_src_b,
  input  logic       cmd_imm_sel,
  input  logic [7:0] cmd_imm,
  input  logic [1:0] cmd_dst,
  output logic [2:0] alu_opcode,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  input  logic [7:0] alu_result,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_zero,
  output logic       rsp_err
);

  // Highest opcode the ALU implements. Anything above it is reported as an
  // error, and it never touches the register file.
  localparam logic [2:0] LAST_LEGAL_OP = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;

  logic [7:0]  regs [4];
  logic [1:0]  dst_q;
  logic        illegal_q;

  logic        accept;
  logic        rsp_done;

  // Accept a command only when both conditions hold: we are idle, and the
  // registered ready flag is up. The registered flag is what the upstream
  // side sees. This keeps the first edge after reset from accepting, because
  // cmd_ready is still low at that edge.
  assign accept   = (state == IDLE) && cmd_ready && cmd_valid;
  assign rsp_done = (state == RESP) && rsp_ready;

  // State register. Reset drops the machine back to IDLE straight away, even
  // in the middle of a command. That throws away the pending write and the
  // pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic. ISSUE always lasts exactly one cycle, which gives the
  // ALU a full clock period to settle. RESP waits as long as the consumer
  // holds rsp_ready low. Because of that, one command takes at least three
  // cycles.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          next_state = ISSUE;
        end
      end
      ISSUE: begin
        next_state = RESP;
      end
      RESP: begin
        if (rsp_done) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Both handshake flags are registered copies of where the FSM is going.
  // So cmd_ready goes high on the same edge that enters IDLE, and rsp_valid
  // goes high on the same edge that enters RESP. Their reset is
  // asynchronous, so an aborted command drops rsp_valid at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      cmd_ready <= (next_state == IDLE);
      rsp_valid <= (next_state == RESP);
    end
  end

  // Operand capture on the accept edge. The ALU inputs are driven straight
  // from these registers. They keep their values until the next accept, so
  // the ALU output stays steady for the whole ISSUE cycle. The destination
  // index and the illegal flag are kept here for the write-back edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_opcode <= 3'd0;
      alu_a      <= 8'h00;
      alu_b      <= 8'h00;
      dst_q      <= 2'd0;
      illegal_q  <= 1'b0;
    end else if (accept) begin
      alu_opcode <= cmd_op;
      alu_a      <= regs[cmd_src_a];
      alu_b      <= cmd_imm_sel ? cmd_imm : regs[cmd_src_b];
      dst_q      <= cmd_dst;
      illegal_q  <= (cmd_op > LAST_LEGAL_OP);
    end
  end

  // Write-back and response capture at the end of ISSUE. A legal op writes
  // the ALU result into the destination register and into the response. An
  // illegal op never looks at alu_result, because the ALU may drive garbage
  // for those opcodes; it just flags the error with a zero payload. Commands
  // run one at a time, so the next command's operand read always sees this
  // write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) begin
        regs[i] <= 8'h00;
      end
      rsp_data <= 8'h00;
      rsp_zero <= 1'b0;
      rsp_err  <= 1'b0;
    end else if (state == ISSUE) begin
      if (illegal_q) begin
        rsp_data <= 8'h00;
        rsp_zero <= 1'b0;
        rsp_err  <= 1'b1;
      end else begin
        regs[dst_q] <= alu_result;
        rsp_data    <= alu_result;
        rsp_zero    <= (alu_result == 8'h00);
        rsp_err     <= 1'b0;
      end
    end
  end

endmodule
